branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed below, clock and reset first.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 br_valid  input  1  branch request presented this cycle.
REQ-005 br_ready  output  1  resolver can accept a request.
REQ-006 br_cond  input  3  condition: 000 ALWAYS, 001 EQ, 010 NE, 011 LT, 100 GT, 101 LE, 110 GE, 111 NEVER.
REQ-007 br_target  input  16  branch target PC.
REQ-008 SR_in  input  2  status register value: 01 less, 11 greater, 10 equal, 00 no compare since reset.
REQ-009 SRw  input  1  status register write in progress this cycle; SR_in stale.
REQ-010 redirect_valid  output  1  one-cycle pulse, taken branch.
REQ-011 redirect_pc  output  16  target PC, valid while redirect_valid=1.
REQ-012 flush  output  1  one-cycle pulse, coincident with redirect_valid.
REQ-013 resolve_done  output  1  one-cycle pulse on every resolved branch, taken or not.
REQ-014 sr_err  output  1  sticky: conditional branch resolved against SR_in=00.
REQ-015 taken_count  output  16  saturating count of taken branches.

Function
REQ-016 SHALL implement a state machine with states IDLE, WAIT_SR, RESOLVE and REDIRECT; all outputs driven from registers or decoded from state only (Moore).
REQ-017 SHALL drive br_ready=1 only in IDLE; handshake accepted when br_valid=1 and br_ready=1 at a rising edge.
REQ-018 On accept, SHALL capture br_cond and br_target; next state WAIT_SR if SRw=1 that cycle, else RESOLVE.
REQ-019 WAIT_SR SHALL last exactly one cycle, then go to RESOLVE.
REQ-020 In RESOLVE, if SRw=1 SHALL remain in RESOLVE without evaluating; otherwise evaluate SR_in that cycle.
REQ-021 Evaluation: EQ taken iff SR_in=10; NE iff SR_in in {01,11}; LT iff 01; GT iff 11; LE iff 01 or 10; GE iff 11 or 10; ALWAYS taken; NEVER not taken.
REQ-022 SR_in=00 with cond other than ALWAYS/NEVER SHALL be not taken and SHALL set sr_err; sr_err clears only on reset.
REQ-023 Taken: next state REDIRECT; not taken: next state IDLE with resolve_done=1 for the following cycle.
REQ-024 REDIRECT SHALL last one cycle with redirect_valid=1, flush=1, resolve_done=1, redirect_pc=captured target, then return to IDLE.
REQ-025 Latency without hazard: accept at edge N, evaluation in cycle N..N+1, redirect_valid high from edge N+2 to N+3.
REQ-026 Each extra SRw cycle SHALL add exactly one cycle of latency.
REQ-027 taken_count SHALL increment by 1 on entry to REDIRECT and saturate at 0xFFFF.
REQ-028 br_valid while br_ready=0 SHALL be ignored; the requester holds it until accepted.
REQ-029 redirect_pc SHALL hold its last value when redirect_valid=0.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, br_ready=1, redirect_valid=0, flush=0, resolve_done=0, sr_err=0, taken_count=0, redirect_pc=0, without waiting for CLK.
REQ-031 Reset asserted in WAIT_SR, RESOLVE or REDIRECT SHALL abort the branch: no redirect pulse, no count increment.
REQ-032 After reset_n rises, the first request SHALL be accepted on the first rising edge with br_valid=1.

Verification
REQ-033 SR_in=10, SRw=0, EQ, target 0x0040 -> redirect_valid, flush and resolve_done high one cycle, 2 edges after accept, redirect_pc=0x0040, taken_count=1.
REQ-034 SR_in=01, GT -> resolve_done one cycle, redirect_valid=0, flush=0, taken_count unchanged.
REQ-035 SRw=1 at accept, then SRw=1 one more cycle in RESOLVE, SR_in changes 11->01, LT -> redirect 2 cycles later than REQ-033, evaluated with 01.
REQ-036 After reset, LT with SR_in=00 -> not taken, sr_err=1 and stays 1 across subsequent ALWAYS branch.
REQ-037 reset_n pulsed low mid-RESOLVE -> all outputs reset asynchronously, no redirect, br_ready=1.
REQ-038 Preload taken_count to 0xFFFE by 2 ALWAYS branches after forcing, or 65535 branches -> stays 0xFFFF on further taken branches.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: accepts one branch at a time, waits out status-register writes,
// evaluates the condition and emits a registered redirect/flush pulse when taken.
module branch_resolver (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_target,
  input  logic [1:0]  SR_in,
  input  logic        SRw,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        resolve_done,
  output logic        sr_err,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {IDLE, WAIT_SR, RESOLVE, REDIRECT} state_t;

  localparam logic [2:0] C_ALWAYS = 3'b000, C_EQ = 3'b001, C_NE = 3'b010, C_LT = 3'b011,
                         C_GT = 3'b100, C_LE = 3'b101, C_GE = 3'b110, C_NEVER = 3'b111;
  localparam logic [1:0] SR_NONE = 2'b00, SR_LT = 2'b01, SR_EQ = 2'b10, SR_GT = 2'b11;

  state_t      state, state_nxt;
  logic [2:0]  cond_q;
  logic [15:0] tgt_q;
  logic        accept, eval, taken, sr_bad;

  assign accept = br_valid && br_ready;
  assign eval   = (state == RESOLVE) && !SRw;

  // Conditions against an unset SR (00) fall through as not taken.
  always_comb begin
    taken = 1'b0;
    case (cond_q)
      C_ALWAYS: taken = 1'b1;
      C_EQ:     taken = (SR_in == SR_EQ);
      C_NE:     taken = (SR_in == SR_LT) || (SR_in == SR_GT);
      C_LT:     taken = (SR_in == SR_LT);
      C_GT:     taken = (SR_in == SR_GT);
      C_LE:     taken = (SR_in == SR_LT) || (SR_in == SR_EQ);
      C_GE:     taken = (SR_in == SR_GT) || (SR_in == SR_EQ);
      C_NEVER:  taken = 1'b0;
      default:  taken = 1'b0;
    endcase
  end

  assign sr_bad = (SR_in == SR_NONE) && (cond_q != C_ALWAYS) && (cond_q != C_NEVER);

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SRw ? WAIT_SR : RESOLVE;
      WAIT_SR:  state_nxt = RESOLVE;
      RESOLVE:  if (eval) state_nxt = taken ? REDIRECT : IDLE;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State-decoded output
  always_comb begin
    br_ready = (state == IDLE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= C_ALWAYS;
      tgt_q  <= '0;
    end else if (accept) begin
      cond_q <= br_cond;
      tgt_q  <= br_target;
    end
  end

  // Pulses are registered off the REDIRECT state, so a reset taken while in
  // REDIRECT never lets a pulse escape.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      resolve_done   <= 1'b0;
      redirect_pc    <= '0;
      sr_err         <= 1'b0;
      taken_count    <= '0;
    end else begin
      redirect_valid <= (state == REDIRECT);
      flush          <= (state == REDIRECT);
      resolve_done   <= (state == REDIRECT) || (eval && !taken);
      if (state == REDIRECT) redirect_pc <= tgt_q;
      if (eval && sr_bad) sr_err <= 1'b1;
      if (eval && taken && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed table-driven bench for branch_resolver plus hand sequences for the
// SR-write stall, mid-resolve reset, sticky sr_err and count saturation.
module tb_branch_resolver;

  logic        CLK, reset_n, br_valid, br_ready, SRw;
  logic [2:0]  br_cond;
  logic [15:0] br_target, redirect_pc, taken_count;
  logic [1:0]  SR_in;
  logic        redirect_valid, flush, resolve_done, sr_err;

  branch_resolver dut (
    .CLK(CLK), .reset_n(reset_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_target(br_target), .SR_in(SR_in), .SRw(SRw),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .resolve_done(resolve_done), .sr_err(sr_err), .taken_count(taken_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  cond;
    logic [15:0] tgt;
    logic [1:0]  sr;
    logic        taken;
    logic        err;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic [15:0] exp_pc  = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // One hazard-free branch: accept at edge N, result registered at N+1 (not taken)
  // or N+2 (taken).
  task automatic run_vec(input vec_t v);
    nvec++;
    chk("ready_idle", {31'b0, br_ready}, 32'd1);
    br_valid = 1'b1; br_cond = v.cond; br_target = v.tgt; SR_in = v.sr; SRw = 1'b0;
    step();
    br_valid = 1'b0;
    chk("ready_busy", {31'b0, br_ready}, 32'd0);
    step();
    chk("rv_n1", {31'b0, redirect_valid}, 32'd0);
    chk("done_n1", {31'b0, resolve_done}, {31'b0, !v.taken});
    step();
    if (v.taken) begin
      exp_cnt = sat_inc(exp_cnt);
      exp_pc  = v.tgt;
      chk("rv_n2", {31'b0, redirect_valid}, 32'd1);
      chk("flush_n2", {31'b0, flush}, 32'd1);
      chk("done_n2", {31'b0, resolve_done}, 32'd1);
      step();
      chk("rv_drop", {31'b0, redirect_valid}, 32'd0);
      chk("flush_drop", {31'b0, flush}, 32'd0);
    end else begin
      chk("rv_nt", {31'b0, redirect_valid}, 32'd0);
      chk("flush_nt", {31'b0, flush}, 32'd0);
      chk("done_drop", {31'b0, resolve_done}, 32'd0);
    end
    chk("pc_hold", {16'b0, redirect_pc}, {16'b0, exp_pc});
    chk("count", {16'b0, taken_count}, {16'b0, exp_cnt});
    chk("sr_err", {31'b0, sr_err}, {31'b0, v.err});
  endtask

  vec_t tbl[15];

  initial begin
    tbl = '{
      '{3'b001, 16'h0040, 2'b10, 1'b1, 1'b0},  // EQ, equal -> taken
      '{3'b100, 16'h0050, 2'b01, 1'b0, 1'b0},  // GT, less -> not
      '{3'b000, 16'h1111, 2'b00, 1'b1, 1'b0},  // ALWAYS ignores unset SR
      '{3'b111, 16'h2222, 2'b11, 1'b0, 1'b0},  // NEVER
      '{3'b010, 16'h3333, 2'b01, 1'b1, 1'b0},  // NE, less
      '{3'b010, 16'h3334, 2'b10, 1'b0, 1'b0},  // NE, equal
      '{3'b011, 16'h4444, 2'b01, 1'b1, 1'b0},  // LT, less
      '{3'b011, 16'h4445, 2'b11, 1'b0, 1'b0},  // LT, greater
      '{3'b100, 16'h5555, 2'b11, 1'b1, 1'b0},  // GT, greater
      '{3'b101, 16'h6666, 2'b10, 1'b1, 1'b0},  // LE, equal
      '{3'b101, 16'h6667, 2'b11, 1'b0, 1'b0},  // LE, greater
      '{3'b110, 16'h7777, 2'b10, 1'b1, 1'b0},  // GE, equal
      '{3'b110, 16'h7778, 2'b01, 1'b0, 1'b0},  // GE, less
      '{3'b001, 16'h8888, 2'b11, 1'b0, 1'b0},  // EQ, greater
      '{3'b111, 16'h9999, 2'b00, 1'b0, 1'b0}   // NEVER with unset SR, no error
    };

    reset_n = 1'b1; br_valid = 1'b0; br_cond = 3'b0; br_target = 16'h0; SR_in = 2'b00; SRw = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, br_ready}, 32'd1);
    chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst_cnt", {16'b0, taken_count}, 32'd0);
    chk("rst_pc", {16'b0, redirect_pc}, 32'd0);
    chk("rst_err", {31'b0, sr_err}, 32'd0);
    step(); step();
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(tbl[i]);

    // SRw at accept plus one stalled RESOLVE cycle; evaluation must use the later SR.
    nvec++;
    br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0BEE; SR_in = 2'b11; SRw = 1'b1;
    step();                     // N: accepted into WAIT_SR
    br_valid = 1'b0;
    step();                     // N+1: RESOLVE, SRw still high
    chk("haz_rv_n1", {31'b0, redirect_valid}, 32'd0);
    step();                     // N+2: stalled
    chk("haz_rv_n2", {31'b0, redirect_valid}, 32'd0);
    chk("haz_done_n2", {31'b0, resolve_done}, 32'd0);
    SRw = 1'b0; SR_in = 2'b01;
    step();                     // N+3: evaluated with 01 -> REDIRECT
    chk("haz_rv_n3", {31'b0, redirect_valid}, 32'd0);
    chk("haz_done_n3", {31'b0, resolve_done}, 32'd0);
    step();                     // N+4: pulse
    exp_cnt = sat_inc(exp_cnt); exp_pc = 16'h0BEE;
    chk("haz_rv_n4", {31'b0, redirect_valid}, 32'd1);
    chk("haz_flush_n4", {31'b0, flush}, 32'd1);
    chk("haz_pc", {16'b0, redirect_pc}, {16'b0, exp_pc});
    chk("haz_cnt", {16'b0, taken_count}, {16'b0, exp_cnt});
    step();
    chk("haz_rv_drop", {31'b0, redirect_valid}, 32'd0);

    // Reset pulsed while in RESOLVE: asynchronous clear, branch aborted.
    nvec++;
    br_valid = 1'b1; br_cond = 3'b000; br_target = 16'hDEAD; SR_in = 2'b10; SRw = 1'b0;
    step();
    br_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    exp_cnt = 16'h0; exp_pc = 16'h0;
    chk("ares_ready", {31'b0, br_ready}, 32'd1);
    chk("ares_cnt", {16'b0, taken_count}, 32'd0);
    chk("ares_pc", {16'b0, redirect_pc}, 32'd0);
    chk("ares_rv", {31'b0, redirect_valid}, 32'd0);
    chk("ares_done", {31'b0, resolve_done}, 32'd0);
    step();
    step();
    chk("ares_rv_hold", {31'b0, redirect_valid}, 32'd0);
    chk("ares_flush_hold", {31'b0, flush}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("ares_no_pulse", {31'b0, redirect_valid}, 32'd0);
    chk("ares_cnt_post", {16'b0, taken_count}, 32'd0);

    // First request after reset accepted immediately; then sticky sr_err.
    run_vec('{3'b000, 16'h1234, 2'b11, 1'b1, 1'b0});
    run_vec('{3'b011, 16'h0100, 2'b00, 1'b0, 1'b1});
    run_vec('{3'b000, 16'h0200, 2'b00, 1'b1, 1'b1});
    run_vec('{3'b110, 16'h0300, 2'b10, 1'b1, 1'b1});

    // Saturation: preload the counter then keep taking branches.
    force dut.taken_count = 16'hFFFE;
    #1 release dut.taken_count;
    exp_cnt = 16'hFFFE;
    run_vec('{3'b000, 16'hAAAA, 2'b10, 1'b1, 1'b1});
    run_vec('{3'b000, 16'hBBBB, 2'b10, 1'b1, 1'b1});
    run_vec('{3'b001, 16'hCCCC, 2'b10, 1'b1, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
